// File: rtl/execute_stage_p_pkg.sv
// rtl/execute_stage_p_pkg.sv - shared ALU/condition encodings, cc layout and condition evaluation
// Used by the decode and execute stages.
//   alu_fun_e  : alufun encodings (8-15 are decoded as ADD by the execute stage)
//   cond_e     : ifun condition encodings (7-15 give Cnd=0)
//   CC_*       : bit positions inside cc = {ZF,SF,OF}, and the cc reset value
package execute_stage_p_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_XOR = 4'd3,
        ALU_OR  = 4'd4,
        ALU_SHL = 4'd5,
        ALU_SAR = 4'd6,
        ALU_MUL = 4'd7
    } alu_fun_e;

    typedef enum logic [3:0] {
        COND_YES = 4'd0,
        COND_LE  = 4'd1,
        COND_L   = 4'd2,
        COND_E   = 4'd3,
        COND_NE  = 4'd4,
        COND_GE  = 4'd5,
        COND_G   = 4'd6
    } cond_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_e;

    localparam int         CC_ZF    = 2;
    localparam int         CC_SF    = 1;
    localparam int         CC_OF    = 0;
    localparam logic [2:0] CC_RESET = 3'b100;

    function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
        logic zf;
        logic sf;
        logic ovf;
        zf  = cc[CC_ZF];
        sf  = cc[CC_SF];
        ovf = cc[CC_OF];
        case (ifun)
            COND_YES: return 1'b1;
            COND_LE:  return (sf ^ ovf) | zf;
            COND_L:   return sf ^ ovf;
            COND_E:   return zf;
            COND_NE:  return ~zf;
            COND_GE:  return ~(sf ^ ovf);
            COND_G:   return ~(sf ^ ovf) & ~zf;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/execute_stage_p_if.sv
// rtl/execute_stage_p_if.sv - operation/result bundle of the execute stage
// Signals:
//   in_valid/in_ready          : operation handshake (accept when both high)
//   alufun, ifun, aluA, aluB   : operation, condition code, operands
//   set_cc                     : update cc when this op completes
//   stall, bubble              : pipeline control of the output register
//   out_valid, valE, Cnd       : registered result
//   cc                         : condition-code register {ZF,SF,OF}
//   busy                       : multiply in progress
// master = the pipeline driving the stage, slave = the execute stage.
interface execute_stage_p_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alufun;
    logic [3:0]   ifun;
    logic [W-1:0] aluA;
    logic [W-1:0] aluB;
    logic         set_cc;
    logic         stall;
    logic         bubble;
    logic         out_valid;
    logic [W-1:0] valE;
    logic         Cnd;
    logic [2:0]   cc;
    logic         busy;

    modport master (
        output in_valid, alufun, ifun, aluA, aluB, set_cc, stall, bubble,
        input  in_ready, out_valid, valE, Cnd, cc, busy
    );

    modport slave (
        input  in_valid, alufun, ifun, aluA, aluB, set_cc, stall, bubble,
        output in_ready, out_valid, valE, Cnd, cc, busy
    );
endinterface

// File: rtl/exec_mul_iter.sv
// rtl/exec_mul_iter.sv - iterative shift-add multiplier, one step per cycle, W steps
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   start        : load operands and begin (ignored fields while running are not sampled)
//   hold         : freeze the final step (counter and accumulator hold)
//   a, b         : operands, captured on start
//   done         : high during the final step; product is valid in that cycle
//   product      : low W bits of a*b as it stands after the current step
module exec_mul_iter #(
    parameter int W = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         hold,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] product
);
    localparam int CW = $clog2(W);

    logic          running;
    logic [CW-1:0] count;
    logic [W-1:0]  acc;
    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic [W-1:0]  acc_next;

    // The accumulator after the current step is exposed directly, so the
    // caller can register the result on the edge that ends the last step.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    assign done    = running && (count == CW'(W - 1));
    assign product = acc_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            count   <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= '0;
            acc     <= '0;
            mcand   <= a;
            mplier  <= b;
        end else if (running && !(done && hold)) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/execute_stage_p.sv
// rtl/execute_stage_p.sv - execute stage: single-cycle ALU, iterative multiply, cc and output register
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : execute_stage_p_if.slave (operation handshake, pipeline control, registered results)
// Parameters:
//   W      : datapath width (8, 16, 32, 64)
//   MUL_EN : 1 = multi-cycle multiply present, 0 = MUL decodes as ADD
module execute_stage_p
    import execute_stage_p_pkg::*;
#(
    parameter int W      = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    execute_stage_p_if.slave   bus
);
    localparam int SH = $clog2(W);

    ex_state_e    state;
    ex_state_e    state_next;

    logic         accept;
    logic         is_mul;
    logic         mul_start;
    logic         mul_done;
    logic [W-1:0] mul_product;
    logic         mul_cnd_q;
    logic         mul_set_cc_q;

    logic [W-1:0] sum;
    logic [W-1:0] diff;
    logic         add_ovf;
    logic         sub_ovf;
    logic [W-1:0] alu_res;
    logic         alu_ovf;
    logic         alu_cnd;

    logic         load_res;
    logic [W-1:0] res_val;
    logic         res_ovf;
    logic         res_cnd;
    logic         res_set_cc;
    logic [2:0]   res_flags;

    logic         out_valid_q;
    logic [W-1:0] valE_q;
    logic         cnd_q;
    logic [2:0]   cc_q;

    assign bus.in_ready = !reset && (state == ST_IDLE) && !bus.stall;
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_mul       = MUL_EN && (bus.alufun == ALU_MUL);

    // Results are B-op-A.
    assign sum     = bus.aluB + bus.aluA;
    assign diff    = bus.aluB - bus.aluA;
    assign add_ovf = (bus.aluA[W-1] == bus.aluB[W-1]) && (bus.aluA[W-1] != sum[W-1]);
    assign sub_ovf = (bus.aluA[W-1] != bus.aluB[W-1]) && (bus.aluB[W-1] != diff[W-1]);

    // Condition uses the cc register as it stands in the accept cycle.
    assign alu_cnd = cond_eval(bus.ifun, cc_q);

    always_comb begin
        alu_res = sum;
        alu_ovf = add_ovf;
        case (bus.alufun)
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = sub_ovf;
            end
            ALU_AND: begin
                alu_res = bus.aluB & bus.aluA;
                alu_ovf = 1'b0;
            end
            ALU_XOR: begin
                alu_res = bus.aluB ^ bus.aluA;
                alu_ovf = 1'b0;
            end
            ALU_OR: begin
                alu_res = bus.aluB | bus.aluA;
                alu_ovf = 1'b0;
            end
            ALU_SHL: begin
                alu_res = bus.aluB << bus.aluA[SH-1:0];
                alu_ovf = 1'b0;
            end
            ALU_SAR: begin
                alu_res = $unsigned($signed(bus.aluB) >>> bus.aluA[SH-1:0]);
                alu_ovf = 1'b0;
            end
            // MUL without the multiplier, and codes 8-15, fall through to ADD.
            default: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
        endcase
    end

    exec_mul_iter #(
        .W (W)
    ) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .hold    (bus.stall),
        .a       (bus.aluA),
        .b       (bus.aluB),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus selection of what (if anything) completes this cycle.
    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        load_res   = 1'b0;
        res_val    = alu_res;
        res_ovf    = alu_ovf;
        res_cnd    = alu_cnd;
        res_set_cc = bus.set_cc;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        mul_start  = 1'b1;
                        state_next = ST_MUL;
                    end else begin
                        load_res = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                // The final step waits out a stall; a bubble on the completing
                // edge still retires the multiply but drops its result.
                if (mul_done && !bus.stall) begin
                    load_res   = 1'b1;
                    res_val    = mul_product;
                    res_ovf    = 1'b0;
                    res_cnd    = mul_cnd_q;
                    res_set_cc = mul_set_cc_q;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        res_flags        = '0;
        res_flags[CC_ZF] = (res_val == '0);
        res_flags[CC_SF] = res_val[W-1];
        res_flags[CC_OF] = res_ovf;
    end

    // Cnd and set_cc of a multiply are fixed at accept time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mul_cnd_q    <= 1'b0;
            mul_set_cc_q <= 1'b0;
        end else if (mul_start) begin
            mul_cnd_q    <= alu_cnd;
            mul_set_cc_q <= bus.set_cc;
        end
    end

    // Output register: stall holds everything, bubble clears, otherwise load
    // a completing result or mark the register empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            valE_q      <= '0;
            cnd_q       <= 1'b0;
            cc_q        <= CC_RESET;
        end else if (!bus.stall) begin
            if (bus.bubble) begin
                out_valid_q <= 1'b0;
                valE_q      <= '0;
                cnd_q       <= 1'b0;
            end else if (load_res) begin
                out_valid_q <= 1'b1;
                valE_q      <= res_val;
                cnd_q       <= res_cnd;
                if (res_set_cc) begin
                    cc_q <= res_flags;
                end
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.valE      = valE_q;
    assign bus.Cnd       = cnd_q;
    assign bus.cc        = cc_q;
    assign bus.busy      = (state == ST_MUL);
endmodule

// File: tb/tb_execute_stage_p.sv
// tb/tb_execute_stage_p.sv - scoreboard bench for execute_stage_p
module tb_execute_stage_p;
    localparam int W  = 8;
    localparam int SH = $clog2(W);
    localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
    localparam longint MINS = -(longint'(1) << (W - 1));

    typedef struct packed {
        logic [W-1:0] v;
        logic [2:0]   f;
    } res_t;

    typedef struct packed {
        logic [W-1:0] v;
        logic         c;
    } exp_t;

    logic clock;
    logic reset;

    execute_stage_p_if #(.W(W)) bus ();

    execute_stage_p #(.W(W), .MUL_EN(1'b1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int           total = 0;
    int           bad   = 0;
    exp_t         exp_q[$];
    logic [2:0]   m_cc = 3'b100;
    int           mul_left = 0;
    logic [W-1:0] mul_val;
    logic [2:0]   mul_flags;
    logic         mul_cnd;
    logic         mul_scc;
    logic         accepted;
    logic         last_valid = 1'b0;
    logic [W-1:0] last_valE = '0;
    logic         last_cnd = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on the operands.
    function automatic res_t alu_ref(input logic [3:0] fun, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, s;
        res_t   r;
        logic   ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = 1'b0;
        case (fun)
            4'd1: begin s = sb - sa; r.v = W'(s); ovf = (s > MAXS) || (s < MINS); end
            4'd2: r.v = a & b;
            4'd3: r.v = a ^ b;
            4'd4: r.v = a | b;
            4'd5: r.v = W'(longint'(b) * (longint'(1) << a[SH-1:0]));
            4'd6: r.v = W'(sb >>> a[SH-1:0]);
            4'd7: r.v = W'(longint'(a) * longint'(b));
            default: begin s = sb + sa; r.v = W'(s); ovf = (s > MAXS) || (s < MINS); end
        endcase
        r.f = {r.v == '0, r.v[W-1], ovf};
        return r;
    endfunction

    function automatic logic cond_ref(input logic [3:0] ifn, input logic [2:0] cc);
        logic zf, sf, of_flag;
        {zf, sf, of_flag} = cc;
        case (ifn)
            4'd0: return 1'b1;
            4'd1: return (sf != of_flag) || zf;
            4'd2: return sf != of_flag;
            4'd3: return zf;
            4'd4: return !zf;
            4'd5: return sf == of_flag;
            4'd6: return (sf == of_flag) && !zf;
            default: return 1'b0;
        endcase
    endfunction

    // One cycle of stimulus; the model decides what lands on the coming edge.
    task automatic drive_cycle(input logic v, input logic [3:0] fun, input logic [3:0] ifn,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic scc, input logic st, input logic bb);
        logic exp_ready;
        logic land;
        logic lscc;
        logic c;
        res_t r;
        exp_t e;
        @(negedge clock);
        bus.in_valid = v;
        bus.alufun   = fun;
        bus.ifun     = ifn;
        bus.aluA     = a;
        bus.aluB     = b;
        bus.set_cc   = scc;
        bus.stall    = st;
        bus.bubble   = bb;
        #1;
        exp_ready = (mul_left == 0) && !st;
        check("in_ready", bus.in_ready, exp_ready);
        check("busy", bus.busy, mul_left != 0);
        accepted = v && exp_ready;
        land = 1'b0;
        lscc = 1'b0;
        c    = 1'b0;
        r    = '0;
        if (mul_left > 0) begin
            if (mul_left == 1) begin
                if (!st) begin
                    land     = !bb;
                    r.v      = mul_val;
                    r.f      = mul_flags;
                    c        = mul_cnd;
                    lscc     = mul_scc;
                    mul_left = 0;
                end
            end else begin
                mul_left--;
            end
        end else if (accepted) begin
            if (fun == 4'd7) begin
                r         = alu_ref(fun, a, b);
                mul_val   = r.v;
                mul_flags = r.f;
                mul_cnd   = cond_ref(ifn, m_cc);
                mul_scc   = scc;
                mul_left  = W;
            end else begin
                r    = alu_ref(fun, a, b);
                c    = cond_ref(ifn, m_cc);
                lscc = scc;
                land = !bb;
            end
        end
        if (land) begin
            e.v = r.v;
            e.c = c;
            exp_q.push_back(e);
            if (lscc) m_cc = r.f;
        end
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 4'd0, 4'd0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: after each edge, compare the output register with the scoreboard.
    always @(posedge clock) begin
        logic st_s;
        logic bb_s;
        exp_t e;
        st_s = bus.stall;
        bb_s = bus.bubble;
        #1;
        if (!reset) begin
            if (st_s) begin
                check("hold_valid", bus.out_valid, last_valid);
                check("hold_valE", bus.valE, last_valE);
                check("hold_cnd", bus.Cnd, last_cnd);
            end else if (bb_s) begin
                check("bubble_valid", bus.out_valid, 0);
                check("bubble_valE", bus.valE, 0);
                check("bubble_cnd", bus.Cnd, 0);
                last_valid = 1'b0;
                last_valE  = '0;
                last_cnd   = 1'b0;
            end else if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("valE", bus.valE, e.v);
                    check("Cnd", bus.Cnd, e.c);
                    last_valid = 1'b1;
                    last_valE  = e.v;
                    last_cnd   = e.c;
                end
            end else begin
                check("idle_valE", bus.valE, last_valE);
                check("idle_cnd", bus.Cnd, last_cnd);
                last_valid = 1'b0;
            end
            check("cc", bus.cc, m_cc);
        end
    end

    task automatic model_reset();
        mul_left = 0;
        m_cc     = 3'b100;
        exp_q.delete();
        last_valid = 1'b0;
        last_valE  = '0;
        last_cnd   = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_valE"}, bus.valE, 0);
        check({tag, "_Cnd"}, bus.Cnd, 0);
        check({tag, "_cc"}, bus.cc, 3'b100);
        check({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        logic         cur_v;
        logic [3:0]   cur_fun;
        logic [3:0]   cur_ifn;
        logic [W-1:0] cur_a;
        logic [W-1:0] cur_b;
        logic         cur_scc;
        logic         pend;

        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.alufun   = 4'd0;
        bus.ifun     = 4'd0;
        bus.aluA     = '0;
        bus.aluB     = '0;
        bus.set_cc   = 1'b0;
        bus.stall    = 1'b0;
        bus.bubble   = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        check_reset_state("rst");
        @(negedge clock);
        reset = 1'b0;
        bus.in_valid = 1'b0;

        // ADD overflow into the sign bit
        drive_cycle(1'b1, 4'd0, 4'd0, 8'h7F, 8'h01, 1'b1, 1'b0, 1'b0);
        @(posedge clock); #2;
        check("add_valE", bus.valE, 8'h80);
        check("add_cc", bus.cc, 3'b011);

        // SUB to zero, then E condition on the next op
        drive_cycle(1'b1, 4'd1, 4'd0, 8'h05, 8'h05, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 4'd0, 4'd3, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #2;
        check("e_cnd", bus.Cnd, 1);
        check("sub_cc", bus.cc, 3'b100);

        // MUL 13*11; a waiting ADD is refused while the multiply runs
        drive_cycle(1'b1, 4'd7, 4'd0, 8'h0D, 8'h0B, 1'b1, 1'b0, 1'b0);
        repeat (W) drive_cycle(1'b1, 4'd0, 4'd0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #2;
        check("mul_valE", bus.valE, 8'h8F);
        drive_cycle(1'b1, 4'd0, 4'd0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);

        // SAR held off by three stall cycles
        repeat (3) drive_cycle(1'b1, 4'd6, 4'd0, 8'h04, 8'hF0, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 4'd6, 4'd0, 8'h04, 8'hF0, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #2;
        check("sar_valE", bus.valE, 8'hFF);

        // ADD with bubble on its load edge
        drive_cycle(1'b1, 4'd0, 4'd0, 8'h01, 8'h01, 1'b1, 1'b0, 1'b1);
        @(posedge clock); #2;
        check("bub_valid", bus.out_valid, 0);
        check("bub_valE", bus.valE, 0);
        check("bub_cc", bus.cc, 3'b010);

        // Reset in the middle of a multiply
        drive_cycle(1'b1, 4'd7, 4'd0, 8'h03, 8'h05, 1'b1, 1'b0, 1'b0);
        repeat (3) idle_cycle();
        @(negedge clock); #2;
        reset = 1'b1;
        #1;
        check_reset_state("midmul");
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        drive_cycle(1'b1, 4'd0, 4'd0, 8'h02, 8'h03, 1'b1, 1'b0, 1'b0);
        @(posedge clock); #2;
        check("post_rst_valid", bus.out_valid, 1);
        check("post_rst_valE", bus.valE, 8'h05);

        // Randomized traffic; an offered op is held until accepted
        pend = 1'b0;
        cur_v = 1'b0; cur_fun = '0; cur_ifn = '0; cur_a = '0; cur_b = '0; cur_scc = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!pend) begin
                cur_v   = ($urandom_range(0, 3) != 0);
                cur_fun = 4'($urandom_range(0, 15));
                cur_ifn = 4'($urandom_range(0, 8));
                cur_a   = W'($urandom);
                cur_b   = ($urandom_range(0, 4) == 0) ? cur_a : W'($urandom);
                cur_scc = 1'($urandom_range(0, 1));
            end
            drive_cycle(cur_v, cur_fun, cur_ifn, cur_a, cur_b, cur_scc,
                        ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
            pend = cur_v && !accepted;
        end

        for (int i = 0; i < W + 4 && mul_left != 0; i++) idle_cycle();
        check("drain_timeout", mul_left, 0);
        idle_cycle();
        @(posedge clock); #3;
        check("leftover", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/execute_stage_p.md
EXECUTE_STAGE_P -- requirements
Module: execute_stage_p

Interface
REQ-001 The block SHALL have parameter W, default 64, meaning datapath width in bits (legal: 8, 16, 32, 64).
REQ-002 The block SHALL have parameter MUL_EN, default 1, meaning the multi-cycle multiply is present (0: MUL behaves as ADD).
REQ-003 The block SHALL have port clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, operation offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit, operation accepted this cycle when in_valid is also high.
REQ-007 The block SHALL have port alufun, input, 4 bits: 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 OR, 5 SHL, 6 SAR, 7 MUL; 8-15 are treated as ADD.
REQ-008 The block SHALL have port ifun, input, 4 bits, the condition code: 0 YES, 1 LE, 2 L, 3 E, 4 NE, 5 GE, 6 G; 7-15 give Cnd=0.
REQ-009 The block SHALL have ports aluA and aluB, input, W bits each, the operands.
REQ-010 The block SHALL have port set_cc, input, 1 bit, update the condition codes on completion.
REQ-011 The block SHALL have ports stall and bubble, input, 1 bit each, pipeline control of the output register.
REQ-012 The block SHALL have port out_valid, output, 1 bit, the output register holds a real result.
REQ-013 The block SHALL have port valE, output, W bits, the registered result.
REQ-014 The block SHALL have port Cnd, output, 1 bit, the registered branch/move condition.
REQ-015 The block SHALL have port cc, output, 3 bits {ZF,SF,OF}, the current condition-code register.
REQ-016 The block SHALL have port busy, output, 1 bit, high while a multiply is in progress.

Function
REQ-017 Results SHALL be computed as B-op-A:
- SUB = aluB-aluA
- SHL = aluB<<aluA[log2(W)-1:0]
- SAR = arithmetic aluB>>aluA[log2(W)-1:0]
- MUL = low W bits of aluA*aluB
- all results truncated to W bits.
REQ-018 Flags:
- ZF = (result==0)
- SF = result[W-1]
- OF for ADD = (A[W-1]==B[W-1]) & (A[W-1]!=result[W-1])
- OF for SUB = (A[W-1]!=B[W-1]) & (B[W-1]!=result[W-1])
- OF is 0 for all other ops.
REQ-019 Cnd SHALL use the cc value in effect at the accept cycle:
- LE = (SF^OF)|ZF
- L = SF^OF
- E = ZF
- NE = ~ZF
- GE = ~(SF^OF)
- G = ~(SF^OF)&~ZF.
REQ-020 The FSM SHALL have states IDLE and MUL.
REQ-021 In IDLE, in_ready SHALL equal ~stall.
REQ-022 In MUL, in_ready SHALL be 0.
REQ-023 A non-MUL op accepted in cycle N SHALL appear in valE/Cnd with out_valid=1 after edge N+1 (latency 1, throughput 1).
REQ-024 An accepted MUL (MUL_EN=1) SHALL capture the operands and ifun/Cnd, then enter MUL.
REQ-025 In MUL, the block SHALL perform one shift-add step per cycle for W cycles, with busy=1 throughout.
REQ-026 The multiply result SHALL load the output register at the edge ending the W-th step (latency W+1 from accept), then the FSM SHALL return to IDLE.
REQ-027 A completing MUL step SHALL wait while stall=1 (the counter holds).
REQ-028 cc SHALL update on the edge the result loads, only if set_cc=1 and bubble=0.
REQ-029 stall=1 SHALL hold out_valid, valE, Cnd and cc unchanged.
REQ-030 bubble=1 with stall=0 SHALL load out_valid=0, valE=0 and Cnd=0, suppress the cc update, and drop any result completing that cycle.
REQ-031 When stall and bubble are both high, stall SHALL win.
REQ-032 With no completion and no stall, out_valid SHALL load 0.
REQ-033 An in_valid=1 with in_ready=0 SHALL not be consumed; the source holds it.

Reset
REQ-034 While reset=1, regardless of clock:
- FSM=IDLE, busy=0
- out_valid=0, valE=0, Cnd=0
- cc=3'b100
- multiply counter/accumulator=0.
REQ-035 A reset asserted mid-multiply SHALL abort it with no cc or output update.
REQ-036 in_ready SHALL be 0 while reset=1.

Structure
REQ-037 alufun/ifun encodings, cc bit indices and the cc reset value 3'b100 SHALL live in a shared package used by the decode and execute stages.
REQ-038 The iterative multiplier SHALL be one sub-module, exec_mul_iter (parameter W; start/done handshake).

Verification
REQ-039 Scenario: W=64, ADD A=0x7FFF_FFFF_FFFF_FFFF, B=1, set_cc=1 -> after 1 cycle valE=0x8000_0000_0000_0000 and cc=3'b011.
REQ-040 Scenario: SUB A=5, B=5, set_cc=1, then next op ifun=3 (E) -> valE=0, cc=3'b100, second result Cnd=1.
REQ-041 Scenario: W=8, MUL A=0x0D, B=0x0B -> busy for 8 cycles, in_ready=0 throughout, and valE=0x8F (143) 9 cycles after accept.
REQ-042 Scenario: SAR A=4, B=0xF0 (W=8) with stall=1 for 3 cycles at the result edge -> the prior outputs hold, then valE=0xFF.
REQ-043 Scenario: ADD with set_cc=1 and bubble=1 at the load edge -> out_valid=0, valE=0, cc unchanged.
REQ-044 Scenario: reset asserted at MUL step 3 -> outputs, FSM and cc return to reset values immediately; the first op after reset is accepted normally.
